// File: rtl/alu_accum_pkg.sv
// Shared op codes, FSM state encoding and index-width helper for the ALU/accumulator bank.
package alu_accum_pkg;

   typedef enum logic [2:0] {
      OP_CLR   = 3'b000,
      OP_HOLD  = 3'b001,
      OP_ADD   = 3'b010,
      OP_LOGIC = 3'b011,
      OP_ORRED = 3'b100,
      OP_CAT   = 3'b101,
      OP_MUL   = 3'b110,
      OP_ACCUM = 3'b111
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_accum_bank_if.sv
// Request/response bundle between the switch/key front end, the accumulator bank and the HEX decoders.
interface alu_accum_bank_if #(
   parameter int WIDTH = 4,
   parameter int NREGS = 4
);
   import alu_accum_pkg::*;

   localparam int IW = idx_w(NREGS);

   logic                 in_valid;
   logic                 in_ready;
   op_e                  op;
   logic [WIDTH-1:0]     a;
   logic [IW-1:0]        src_sel;
   logic [IW-1:0]        dst_sel;
   logic [IW-1:0]        rd_sel;
   logic [2*WIDTH-1:0]   acc_out;
   logic                 done;
   logic                 flag_zero;
   logic                 flag_carry;

   modport master (
      output in_valid, op, a, src_sel, dst_sel, rd_sel,
      input  in_ready, acc_out, done, flag_zero, flag_carry
   );

   modport slave (
      input  in_valid, op, a, src_sel, dst_sel, rd_sel,
      output in_ready, acc_out, done, flag_zero, flag_carry
   );

endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks after start.
module shift_add_mul #(
   parameter int WIDTH = 4
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic [2*WIDTH-1:0] product,
   output logic               last
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [PW-1:0]    mcand;
   logic [PW-1:0]    psum;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;

   // product already includes this cycle's partial term, so it is final while last is high
   assign product = psum + (mplier[0] ? mcand : '0);
   assign last    = busy && (cnt == CNT_LAST);

   always_ff @(posedge CLK) begin
      if (!reset) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
         if (last) busy <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (start) begin
         mcand  <= PW'(a);
         mplier <= b;
         psum   <= '0;
      end else if (busy) begin
         psum   <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/alu_accum_bank.sv
// ALU feeding a bank of NREGS accumulators, 2*WIDTH bits each, with an iterative multiply.
// Build option: ACCUM_SATURATE_EN clamps ACCUM to all-ones on carry instead of wrapping.
module alu_accum_bank
   import alu_accum_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREGS = 4
) (
   input  logic            CLK,
   input  logic            reset,
   alu_accum_bank_if.slave bus
);
   localparam int IW = idx_w(NREGS);
   localparam int AW = 2 * WIDTH;

   logic [AW-1:0]    acc [NREGS];
   state_e           state, state_nx;
   logic             in_ready, accept, mul_start;
   logic             mul_busy, mul_last;
   logic [AW-1:0]    mul_prod;
   logic [IW-1:0]    mul_dst;
   logic [WIDTH-1:0] b_src;
   logic [AW-1:0]    acc_dst, res;
   logic [WIDTH:0]   add_sum;
   logic [AW:0]      accum_sum;
   logic             res_wr, res_carry;
   logic             done_q, zero_q, carry_q;

   function automatic logic in_range(input logic [IW-1:0] sel);
      return int'(sel) < NREGS;
   endfunction

   function automatic logic [AW-1:0] accum_result(input logic [AW:0] s);
`ifdef ACCUM_SATURATE_EN
      return s[AW] ? '1 : s[AW-1:0];
`else
      return s[AW-1:0];
`endif
   endfunction

   always_ff @(posedge CLK) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid && bus.op == OP_MUL) begin
               mul_start = 1'b1;
               state_nx  = ST_MUL;
            end
         end
         ST_MUL: if (mul_last || !mul_busy) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign accept = bus.in_valid && in_ready;

   // Single-cycle result, computed from the live inputs so the write at acceptance is the snapshot
   always_comb begin
      b_src   = '0;
      acc_dst = '0;
      if (in_range(bus.src_sel)) b_src   = acc[bus.src_sel][WIDTH-1:0];
      if (in_range(bus.dst_sel)) acc_dst = acc[bus.dst_sel];
      add_sum   = {1'b0, bus.a} + {1'b0, b_src};
      accum_sum = {1'b0, acc_dst} + (AW+1)'(bus.a);
      res       = '0;
      res_wr    = 1'b1;
      res_carry = 1'b0;
      case (bus.op)
         OP_CLR:   res = '0;
         OP_HOLD:  res_wr = 1'b0;
         OP_ADD:   begin res = AW'(add_sum); res_carry = add_sum[WIDTH]; end
         OP_LOGIC: res = {~(bus.a & b_src), ~(bus.a ^ b_src)};
         OP_ORRED: res = AW'(|{bus.a, b_src});
         OP_CAT:   res = {bus.a, ~b_src};
         OP_MUL:   res_wr = 1'b0;
         OP_ACCUM: begin res = accum_result(accum_sum); res_carry = accum_sum[AW]; end
         default:  res_wr = 1'b0;
      endcase
   end

   shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .CLK     (CLK),
      .reset   (reset),
      .start   (mul_start),
      .a       (bus.a),
      .b       (b_src),
      .busy    (mul_busy),
      .product (mul_prod),
      .last    (mul_last)
   );

   // Register bank write port and flags; single-cycle and multiply writes never coincide
   always_ff @(posedge CLK) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) acc[i] <= '0;
         mul_dst <= '0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         done_q <= (accept && !mul_start) || mul_last;
         if (mul_start) mul_dst <= bus.dst_sel;
         if (accept && res_wr && in_range(bus.dst_sel)) begin
            acc[bus.dst_sel] <= res;
            zero_q           <= (res == '0);
            carry_q          <= res_carry;
         end
         if (mul_last && in_range(mul_dst)) begin
            acc[mul_dst] <= mul_prod;
            zero_q       <= (mul_prod == '0);
            carry_q      <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.acc_out    = in_range(bus.rd_sel) ? acc[bus.rd_sel] : '0;
   assign bus.done       = done_q;
   assign bus.flag_zero  = zero_q;
   assign bus.flag_carry = carry_q;

endmodule

// File: tb/tb_alu_accum_bank.sv
// Bench for alu_accum_bank (WIDTH=4, NREGS=4): directed ops, a per-cycle model compare and literal spot checks.
module tb_alu_accum_bank;
   import alu_accum_pkg::*;

   localparam int W   = 4;
   localparam int N   = 4;
   localparam int MW  = 15;
   localparam int MAW = 255;

   logic CLK = 1'b0;
   logic reset = 1'b0;

   alu_accum_bank_if #(.WIDTH(W), .NREGS(N)) bus();

   alu_accum_bank #(.WIDTH(W), .NREGS(N)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model: accumulator contents, flags, done and remaining multiply cycles
   int m_acc [N];
   int m_left = 0;
   int m_prod = 0;
   int m_dst  = 0;
   bit m_done = 1'b0;
   bit m_zero = 1'b0;
   bit m_carry = 1'b0;

   function automatic int f_res(input op_e op, input int a, input int b, input int accd);
      case (op)
         OP_ADD:   return a + b;
         OP_LOGIC: return ((~(a & b) & MW) << W) | (~(a ^ b) & MW);
         OP_ORRED: return (a != 0 || b != 0) ? 1 : 0;
         OP_CAT:   return (a << W) | (~b & MW);
         OP_ACCUM: begin
            if (accd + a <= MAW) return accd + a;
`ifdef ACCUM_SATURATE_EN
            return MAW;
`else
            return accd + a - (MAW + 1);
`endif
         end
         default:  return 0;
      endcase
   endfunction

   function automatic bit f_carry(input op_e op, input int a, input int b, input int accd);
      if (op == OP_ADD)   return (a + b) > MW;
      if (op == OP_ACCUM) return (accd + a) > MAW;
      return 1'b0;
   endfunction

   function automatic bit f_wr(input op_e op);
      return !(op == OP_HOLD || op == OP_MUL);
   endfunction

   always @(posedge CLK) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) m_acc[i] <= 0;
         m_left  <= 0;
         m_done  <= 1'b0;
         m_zero  <= 1'b0;
         m_carry <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_acc[m_dst] <= m_prod;
               m_zero       <= (m_prod == 0);
               m_carry      <= 1'b0;
               m_done       <= 1'b1;
            end
         end else if (bus.in_valid) begin
            m_done <= (bus.op != OP_MUL);
            if (bus.op == OP_MUL) begin
               m_left <= W;
               m_dst  <= int'(bus.dst_sel);
               m_prod <= int'(bus.a) * (m_acc[bus.src_sel] & MW);
            end else if (f_wr(bus.op)) begin
               m_acc[bus.dst_sel] <= f_res(bus.op, int'(bus.a), m_acc[bus.src_sel] & MW, m_acc[bus.dst_sel]);
               m_zero  <= (f_res(bus.op, int'(bus.a), m_acc[bus.src_sel] & MW, m_acc[bus.dst_sel]) == 0);
               m_carry <= f_carry(bus.op, int'(bus.a), m_acc[bus.src_sel] & MW, m_acc[bus.dst_sel]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic issue(input op_e op, input int a, input int src, input int dst);
      bus.op       = op;
      bus.a        = 4'(a);
      bus.src_sel  = 2'(src);
      bus.dst_sel  = 2'(dst);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic peek(input int sel, output int val);
      @(negedge CLK);
      #1;
      bus.rd_sel = 2'(sel);
      #1;
      val = int'(bus.acc_out);
   endtask

   initial begin
      fork
         begin : compare
            forever begin
               @(negedge CLK);
               if (chk_en) begin
                  check("cyc_acc_out", int'(bus.acc_out), m_acc[bus.rd_sel]);
                  check("cyc_in_ready", int'(bus.in_ready), (m_left == 0) ? 1 : 0);
                  check("cyc_done", int'(bus.done), int'(m_done));
                  check("cyc_flag_zero", int'(bus.flag_zero), int'(m_zero));
                  check("cyc_flag_carry", int'(bus.flag_carry), int'(m_carry));
               end
            end
         end
         begin : stimulus
            int v;
            int low;
            int dones;
            bit seen;
            bus.in_valid = 1'b0;
            bus.op       = OP_HOLD;
            bus.a        = '0;
            bus.src_sel  = '0;
            bus.dst_sel  = '0;
            bus.rd_sel   = '0;
            reset = 1'b0;
            step();
            step();
            reset  = 1'b1;
            chk_en = 1'b1;
            check("rst_in_ready", int'(bus.in_ready), 1);
            check("rst_done", int'(bus.done), 0);
            check("rst_flag_zero", int'(bus.flag_zero), 0);
            check("rst_flag_carry", int'(bus.flag_carry), 0);
            for (int r = 0; r < N; r++) begin
               peek(r, v);
               check("rst_acc", v, 0);
            end

            issue(OP_ACCUM, 15, 0, 1);
            check("accum_done", int'(bus.done), 1);
            issue(OP_ADD, 9, 1, 0);
            check("add_done", int'(bus.done), 1);
            check("add_in_ready", int'(bus.in_ready), 1);
            peek(1, v);
            check("acc1_accum", v, 'h0F);
            peek(0, v);
            check("add_9_15", v, 'h18);
            check("add_9_15_carry", int'(bus.flag_carry), 1);
            issue(OP_ADD, 15, 1, 0);
            peek(0, v);
            check("add_15_15", v, 'h1E);
            check("add_15_15_carry", int'(bus.flag_carry), 1);
            issue(OP_ADD, 0, 1, 3);
            peek(3, v);
            check("add_0_15", v, 'h0F);
            check("add_0_15_carry", int'(bus.flag_carry), 0);
            issue(OP_LOGIC, 'hA, 1, 3);
            peek(3, v);
            check("logic_a_f", v, 'h5A);
            issue(OP_ORRED, 0, 2, 3);
            peek(3, v);
            check("orred_zero", v, 0);
            check("orred_zero_flag", int'(bus.flag_zero), 1);
            issue(OP_ORRED, 0, 1, 3);
            peek(3, v);
            check("orred_one", v, 1);
            issue(OP_HOLD, 9, 0, 3);
            check("hold_done", int'(bus.done), 1);
            check("hold_flag_zero", int'(bus.flag_zero), 0);

            // multiply 13 * acc1 (15), with an ignored CLR presented while busy
            bus.op       = OP_MUL;
            bus.a        = 4'd13;
            bus.src_sel  = 2'd1;
            bus.dst_sel  = 2'd2;
            bus.in_valid = 1'b1;
            step();
            bus.op = OP_CLR;
            low    = 0;
            dones  = 0;
            seen   = 1'b0;
            for (int k = 0; k < 12; k++) begin
               @(negedge CLK);
               if (bus.done) dones++;
               if (k == 1) bus.in_valid = 1'b0;
               if (bus.in_ready) begin
                  seen = 1'b1;
                  break;
               end
               low++;
            end
            bus.in_valid = 1'b0;
            check("mul_ready_timeout", int'(seen), 1);
            @(negedge CLK);
            if (bus.done) dones++;
            check("mul_ready_low_cycles", low, 4);
            check("mul_done_pulses", dones, 1);
            peek(2, v);
            check("mul_13_15", v, 'hC3);
            check("model_mul_13_15", m_acc[2], 'hC3);
            check("mul_flag_carry", int'(bus.flag_carry), 0);
            issue(OP_CLR, 0, 0, 2);
            peek(2, v);
            check("clr_after_mul", v, 0);
            check("clr_flag_zero", int'(bus.flag_zero), 1);

            // reset after two multiply iterations
            bus.op       = OP_MUL;
            bus.a        = 4'd13;
            bus.src_sel  = 2'd1;
            bus.dst_sel  = 2'd2;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            step();
            step();
            reset = 1'b0;
            step();
            reset = 1'b1;
            check("midrst_in_ready", int'(bus.in_ready), 1);
            check("midrst_done", int'(bus.done), 0);
            dones = 0;
            repeat (6) begin
               @(negedge CLK);
               if (bus.done) dones++;
            end
            check("midrst_no_done", dones, 0);
            for (int r = 0; r < N; r++) begin
               peek(r, v);
               check("midrst_acc", v, 0);
            end

            issue(OP_CLR, 0, 0, 0);
            issue(OP_CAT, 15, 0, 3);
            peek(3, v);
            check("cat_f_0", v, 'hFF);
            issue(OP_ACCUM, 2, 0, 3);
            peek(3, v);
`ifdef ACCUM_SATURATE_EN
            check("accum_ovf", v, 'hFF);
`else
            check("accum_ovf", v, 'h01);
`endif
            check("accum_ovf_carry", int'(bus.flag_carry), 1);
            check("accum_ovf_zero", int'(bus.flag_zero), 0);
            repeat (3) @(negedge CLK);
         end
         begin : watchdog
            #200000;
            check("watchdog_timeout", 0, 1);
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
